// File: rtl/jtframe_pocket_i2s.sv
// I2S audio output for the Pocket: holds core samples, serialises 32-bit-slot frames at 48 kHz, counts underruns.
// Define JTFRAME_I2S_MONO_EN to downmix both channels to (L+R)>>>1 at capture.
module jtframe_pocket_i2s #(
  parameter bit SIGNED_SND = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] snd_left,
  input  logic [15:0] snd_right,
  input  logic        snd_sample,
  input  logic        mute,
  output logic        audio_sclk,
  output logic        audio_lrck,
  output logic        audio_dac,
  output logic        sample_ack,
  output logic [7:0]  underrun
);
  logic [1:0]  div;
  logic [5:0]  bitcnt, bitcnt_nx;
  logic [31:0] hold, frame, cap;
  logic [15:0] cnv_l, cnv_r;
  logic [3:0]  bit_idx;
  logic        fresh, fe, load, dac_nx;

  // Offset binary becomes two's complement by flipping the MSB
  assign cnv_l = {snd_left[15]  ^ ~SIGNED_SND, snd_left[14:0]};
  assign cnv_r = {snd_right[15] ^ ~SIGNED_SND, snd_right[14:0]};

`ifdef JTFRAME_I2S_MONO_EN
  logic [16:0] mix_sum;
  assign mix_sum = {cnv_l[15], cnv_l} + {cnv_r[15], cnv_r};
  assign cap     = {mix_sum[16:1], mix_sum[16:1]};
`else
  assign cap = {cnv_l, cnv_r};
`endif

  assign audio_sclk = div[1];
  assign fe         = div == 2'd3;
  assign bitcnt_nx  = bitcnt + 6'd1;
  assign load       = fe && bitcnt_nx == 6'd0;
  // Slot bits 1..16 map to word bits 15..0
  assign bit_idx    = 4'd0 - bitcnt_nx[3:0];

  always_comb begin
    // NOTE: default assigned first so the combinational block never infers a latch
    dac_nx = 1'b0;
    if (bitcnt_nx[4:0] inside {[5'd1:5'd16]})
      dac_nx = bitcnt_nx[5] ? frame[{1'b0, bit_idx}] : frame[{1'b1, bit_idx}];
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; hold and frame are plain registers and are reset too
    if (!rst_n) begin
      div        <= '0;
      bitcnt     <= '0;
      hold       <= '0;
      frame      <= '0;
      fresh      <= 1'b0;
      underrun   <= '0;
      audio_lrck <= 1'b0;
      audio_dac  <= 1'b0;
      sample_ack <= 1'b0;
    end else begin
      div        <= div + 2'd1;
      sample_ack <= load;
      if (fe) begin
        bitcnt     <= bitcnt_nx;
        audio_lrck <= bitcnt_nx[5];
        audio_dac  <= dac_nx;
      end
      if (load) begin
        frame <= mute ? '0 : hold;
        if (!fresh && underrun != 8'hFF) underrun <= underrun + 8'd1;
      end
      // A strobe coinciding with a frame load refills hold after the old value was taken
      if (snd_sample) begin
        hold  <= cap;
        fresh <= 1'b1;
      end else if (load) begin
        fresh <= 1'b0;
      end
    end
  end
endmodule
